// File: rtl/gpio_pkg.sv
// Register offsets and reset constants for the GPIO peripheral.
// Shared with firmware headers, so the numbering must stay stable.
package gpio_pkg;

    localparam int GPIO_TRIS    = 0;
    localparam int GPIO_OUT     = 1;
    localparam int GPIO_IN      = 2;
    localparam int GPIO_OUT_SET = 3;
    localparam int GPIO_OUT_CLR = 4;
    localparam int GPIO_OUT_TGL = 5;
    localparam int GPIO_IE      = 6;
    localparam int GPIO_RISE    = 7;
    localparam int GPIO_FALL    = 8;
    localparam int GPIO_IFLAG   = 9;

    // All pins come out of reset as inputs
    localparam logic [7:0] GPIO_TRIS_RESET = 8'hFF;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser for asynchronous pad inputs.
// Every bit is treated independently, with no cross-bit coherency.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral for the TRSQ8 bus: direction/output registers with atomic
// set/clear/toggle, synchronised inputs and per-pin edge interrupts.
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH             = 8,
    parameter int ADDR_LSB          = 0,
    parameter int OPT_MEM_ADDR_BITS = 3,
    parameter int SYNC_STAGES       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       addr,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] port_i,
    output logic [WIDTH-1:0] port_o,
    output logic [WIDTH-1:0] port_t,
    output logic             irq
);

    localparam int LW = OPT_MEM_ADDR_BITS + 1;

    logic [LW-1:0]    loc_addr;
    logic [WIDTH-1:0] din_w;
    logic [WIDTH-1:0] tris_r, out_r, ie_r, rise_r, fall_r, iflag_r;
    logic [WIDTH-1:0] in_sync, prev_r;
    logic [WIDTH-1:0] rise_hit, fall_hit, w1c_mask;
    logic [7:0]       rdata;
    logic             unused_bits;

    assign loc_addr    = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
    assign din_w       = din[WIDTH-1:0];
    assign unused_bits = ^{addr, din};

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (port_i),
        .q     (in_sync)
    );

    // Edges are seen on every pin, including pins currently driven as outputs
    assign rise_hit = in_sync & ~prev_r & rise_r;
    assign fall_hit = ~in_sync & prev_r & fall_r;
    assign w1c_mask = (wr_en && loc_addr == LW'(GPIO_IFLAG)) ? din_w : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tris_r  <= GPIO_TRIS_RESET[WIDTH-1:0];
            out_r   <= '0;
            ie_r    <= '0;
            rise_r  <= '0;
            fall_r  <= '0;
            iflag_r <= '0;
            prev_r  <= '0;
            irq     <= 1'b0;
        end else begin
            prev_r  <= in_sync;
            irq     <= |(iflag_r & ie_r);
            // A fresh edge outranks a simultaneous write-1-to-clear
            iflag_r <= (iflag_r & ~w1c_mask) | rise_hit | fall_hit;
            if (wr_en) begin
                case (loc_addr)
                    LW'(GPIO_TRIS):    tris_r <= din_w;
                    LW'(GPIO_OUT):     out_r  <= din_w;
                    LW'(GPIO_OUT_SET): out_r  <= out_r | din_w;
                    LW'(GPIO_OUT_CLR): out_r  <= out_r & ~din_w;
                    LW'(GPIO_OUT_TGL): out_r  <= out_r ^ din_w;
                    LW'(GPIO_IE):      ie_r   <= din_w;
                    LW'(GPIO_RISE):    rise_r <= din_w;
                    LW'(GPIO_FALL):    fall_r <= din_w;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (loc_addr)
            LW'(GPIO_TRIS):  rdata[WIDTH-1:0] = tris_r;
            LW'(GPIO_OUT):   rdata[WIDTH-1:0] = out_r;
            LW'(GPIO_IN):    rdata[WIDTH-1:0] = in_sync;
            LW'(GPIO_IE):    rdata[WIDTH-1:0] = ie_r;
            LW'(GPIO_RISE):  rdata[WIDTH-1:0] = rise_r;
            LW'(GPIO_FALL):  rdata[WIDTH-1:0] = fall_r;
            LW'(GPIO_IFLAG): rdata[WIDTH-1:0] = iflag_r;
            default:         rdata = '0;
        endcase
    end

    // A write wins over a read in the same cycle, leaving dout untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= 8'h00;
        end else if (rd_en && !wr_en) begin
            dout <= rdata;
        end
    end

    assign port_o = out_r;
    assign port_t = tris_r;

endmodule

// File: tb/tb_gpio_irq.sv
// Randomised and directed bench for gpio_irq; an 8-pin and a 4-pin instance
// share one bus and are both checked against a register-level model.
module tb_gpio_irq;
    import gpio_pkg::*;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr, din, port_i;
    logic       wr_en, rd_en;
    logic [7:0] dout0, dout1, port_o0, port_t0;
    logic [3:0] port_o1, port_t1;
    logic       irq0, irq1;

    int n_checks = 0;
    int n_errors = 0;

    gpio_irq #(.WIDTH(8), .ADDR_LSB(0), .OPT_MEM_ADDR_BITS(3), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout0),
        .wr_en(wr_en), .rd_en(rd_en), .port_i(port_i), .port_o(port_o0),
        .port_t(port_t0), .irq(irq0)
    );

    gpio_irq #(.WIDTH(4), .ADDR_LSB(0), .OPT_MEM_ADDR_BITS(3), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout1),
        .wr_en(wr_en), .rd_en(rd_en), .port_i(port_i[3:0]), .port_o(port_o1),
        .port_t(port_t1), .irq(irq1)
    );

    always #5 clk = ~clk;

    // Model: register contents per instance plus a history of pin samples
    logic [7:0] mask    [2] = '{8'hFF, 8'h0F};
    logic [7:0] m_tris  [2];
    logic [7:0] m_out   [2];
    logic [7:0] m_ie    [2];
    logic [7:0] m_rise  [2];
    logic [7:0] m_fall  [2];
    logic [7:0] m_iflag [2];
    logic [7:0] m_dout  [2];
    logic [7:0] m_irq   [2];
    logic [7:0] hist[$];

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tris[k] = mask[k]; m_out[k] = 0; m_ie[k] = 0; m_rise[k] = 0;
            m_fall[k] = 0; m_iflag[k] = 0; m_dout[k] = 0; m_irq[k] = 0;
        end
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_front(8'h00);
    endtask

    function automatic logic [7:0] model_read(int k, int loc, logic [7:0] in_v);
        case (loc)
            GPIO_TRIS:  return m_tris[k];
            GPIO_OUT:   return m_out[k];
            GPIO_IN:    return in_v;
            GPIO_IE:    return m_ie[k];
            GPIO_RISE:  return m_rise[k];
            GPIO_FALL:  return m_fall[k];
            GPIO_IFLAG: return m_iflag[k];
            default:    return 8'h00;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs now on the bus.
    // hist[j] is the pin sample taken j edges ago; the synchronised value seen
    // before this edge is the sample from S edges back.
    task automatic model_step();
        int loc;
        logic [7:0] in_k, prev_k, rd_val, edges, w1c, d;
        hist.push_front(port_i);
        while (hist.size() > S + 2) void'(hist.pop_back());
        loc = int'(addr[3:0]);
        for (int k = 0; k < 2; k++) begin
            in_k   = hist[S] & mask[k];
            prev_k = hist[S+1] & mask[k];
            d      = din & mask[k];
            rd_val = model_read(k, loc, in_k);
            m_irq[k] = {7'b0, |(m_iflag[k] & m_ie[k])};
            edges = (in_k & ~prev_k & m_rise[k]) | (~in_k & prev_k & m_fall[k]);
            w1c   = (wr_en && loc == GPIO_IFLAG) ? d : 8'h00;
            m_iflag[k] = (m_iflag[k] & ~w1c) | edges;
            if (wr_en) begin
                case (loc)
                    GPIO_TRIS:    m_tris[k] = d;
                    GPIO_OUT:     m_out[k]  = d;
                    GPIO_OUT_SET: m_out[k]  = m_out[k] | d;
                    GPIO_OUT_CLR: m_out[k]  = m_out[k] & ~d;
                    GPIO_OUT_TGL: m_out[k]  = m_out[k] ^ d;
                    GPIO_IE:      m_ie[k]   = d;
                    GPIO_RISE:    m_rise[k] = d;
                    GPIO_FALL:    m_fall[k] = d;
                    default: ;
                endcase
            end else if (rd_en) begin
                m_dout[k] = rd_val;
            end
        end
    endtask

    task automatic compare_all();
        checkOutput("port_o8", port_o0, m_out[0]);
        checkOutput("port_t8", port_t0, m_tris[0]);
        checkOutput("irq8", {7'b0, irq0}, m_irq[0]);
        checkOutput("dout8", dout0, m_dout[0]);
        checkOutput("port_o4", {4'h0, port_o1}, m_out[1]);
        checkOutput("port_t4", {4'h0, port_t1}, m_tris[1]);
        checkOutput("irq4", {7'b0, irq1}, m_irq[1]);
        checkOutput("dout4", dout1, m_dout[1]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        wr_en = w; rd_en = r; addr = a; din = d;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, 8'(a), d);
    endtask

    task automatic rd(input int a);
        applyStimulus(1'b0, 1'b1, 8'(a), 8'h00);
    endtask

    initial begin
        reset = 1'b1; addr = 0; din = 0; wr_en = 0; rd_en = 0; port_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_port_t", port_t0, 8'hFF);
        checkOutput("rst_port_o", port_o0, 8'h00);
        checkOutput("rst_irq", {7'b0, irq0}, 8'h00);
        rd(GPIO_TRIS);  checkOutput("rst_tris", dout0, 8'hFF);
                        checkOutput("rst_tris4", dout1, 8'h0F);
        rd(GPIO_OUT);   checkOutput("rst_out", dout0, 8'h00);
        rd(GPIO_IN);    checkOutput("rst_in", dout0, 8'h00);
        rd(GPIO_IE);    checkOutput("rst_ie", dout0, 8'h00);
        rd(GPIO_IFLAG); checkOutput("rst_iflag", dout0, 8'h00);

        // Output register and atomic ops
        wr(GPIO_TRIS, 8'h0F);    checkOutput("tris_w", port_t0, 8'h0F);
        wr(GPIO_OUT, 8'hA5);     checkOutput("out_w", port_o0, 8'hA5);
        wr(GPIO_OUT_SET, 8'h0A); checkOutput("out_set", port_o0, 8'hAF);
        wr(GPIO_OUT_CLR, 8'h81); checkOutput("out_clr", port_o0, 8'h2E);
        wr(GPIO_OUT_TGL, 8'hFF); checkOutput("out_tgl", port_o0, 8'hD1);
                                 checkOutput("out_tgl4", {4'h0, port_o1}, 8'h01);
        rd(GPIO_OUT_SET);        checkOutput("rd_wo", dout0, 8'h00);

        // Rising edge on pin 0 with explicit latency
        wr(GPIO_RISE, 8'h01);
        wr(GPIO_IE, 8'h01);
        port_i = 8'h01;
        idle(3);                 checkOutput("rise_irq_early", {7'b0, irq0}, 8'h00);
        idle(1);                 checkOutput("rise_irq", {7'b0, irq0}, 8'h01);
        rd(GPIO_IFLAG);          checkOutput("rise_flag", dout0, 8'h01);
        wr(GPIO_IFLAG, 8'h01);
        idle(1);                 checkOutput("w1c_irq", {7'b0, irq0}, 8'h00);
        rd(GPIO_IFLAG);          checkOutput("w1c_flag", dout0, 8'h00);

        // Falling edge on pin 7 masked by IE, then unmasked
        wr(GPIO_FALL, 8'h80);
        wr(GPIO_IE, 8'h00);
        port_i = 8'h81;
        idle(4);
        port_i = 8'h01;
        idle(4);                 checkOutput("fall_masked", {7'b0, irq0}, 8'h00);
        rd(GPIO_IFLAG);          checkOutput("fall_flag", dout0, 8'h80);
        wr(GPIO_IE, 8'h80);
        idle(1);                 checkOutput("ie_unmask", {7'b0, irq0}, 8'h01);

        // W1C colliding with a new rising edge on pin 0
        wr(GPIO_IFLAG, 8'hFF);
        wr(GPIO_IE, 8'h01);
        port_i = 8'h00; idle(4);
        port_i = 8'h01; idle(4);
        port_i = 8'h00; idle(4);
        port_i = 8'h01; idle(2);
        wr(GPIO_IFLAG, 8'h01);
        idle(1);                 checkOutput("collide_irq", {7'b0, irq0}, 8'h01);
        rd(GPIO_IFLAG);          checkOutput("collide_flag", dout0, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'(GPIO_OUT), 8'h3C);
        checkOutput("wr_rd_out", port_o0, 8'h3C);
        checkOutput("wr_rd_dout", dout0, 8'h01);

        // Narrow instance ignores upper bits
        wr(GPIO_OUT, 8'hFF);
        rd(GPIO_OUT);            checkOutput("w4_out", dout1, 8'h0F);
                                 checkOutput("w4_port_o", {4'h0, port_o1}, 8'h0F);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) port_i = 8'($urandom);
            wr_en = ($urandom_range(9) < 3);
            rd_en = ($urandom_range(9) < 4);
            addr  = 8'($urandom_range(15));
            din   = 8'($urandom);
            cycle();
        end
        wr_en = 0; rd_en = 0;

        // Asynchronous reset with a flag pending
        wr(GPIO_RISE, 8'hFF);
        wr(GPIO_IE, 8'hFF);
        wr(GPIO_OUT, 8'h5A);
        port_i = 8'h00; idle(4);
        port_i = 8'h0F; idle(4);
        checkOutput("pre_rst_irq", {7'b0, irq0}, 8'h01);
        reset = 1'b1;
        #1;
        model_reset();
        checkOutput("async_irq", {7'b0, irq0}, 8'h00);
        checkOutput("async_irq4", {7'b0, irq1}, 8'h00);
        checkOutput("async_port_t", port_t0, 8'hFF);
        checkOutput("async_port_o", port_o0, 8'h00);
        checkOutput("async_dout", dout0, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);                 checkOutput("post_rst_irq", {7'b0, irq0}, 8'h00);
        rd(GPIO_IFLAG);          checkOutput("post_rst_flag", dout0, 8'h00);
        rd(GPIO_IN);             checkOutput("post_rst_in", dout0, 8'h0F);
        rd(GPIO_TRIS);           checkOutput("post_rst_tris", dout0, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
